adc_lane_packer: RTL
====================

# adc_lane_packer

Front-end gearbox feeding the wideband real PFB. Accepts IN_LANES ADC samples per valid beat and packs R = LANES/IN_LANES consecutive beats into one LANES-wide word, with the earliest sample in lane 0. It also converts offset-binary samples to two's complement if required and produces the PFB's `sync_in` aligned to the first sample of a frame. It sits between the ADC capture logic and `pfb_real_wideband`.

## Interface
- DIN_WIDTH, 8: bits per sample.
- IN_LANES, 2: samples per input beat; must divide LANES.
- LANES, 4: samples per output word; must equal the PFB LANES.
- PFB_SIZE, 64: PFB frame length in samples; multiple of LANES.
- OFFSET_BINARY, 0: 1 means invert each sample MSB before packing.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- din  in  IN_LANES*DIN_WIDTH  input samples; sample k is `din[DIN_WIDTH*k +: DIN_WIDTH]`, earliest at k=0.
- din_valid  in  1  input beat qualifier.
- sync_in  in  1  frame-alignment request; sampled only when din_valid=1.
- dout  out  LANES*DIN_WIDTH  packed word; lane i is `dout[DIN_WIDTH*i +: DIN_WIDTH]`.
- dout_valid  out  1  one-cycle word strobe.
- sync_out  out  1  frame-start marker; feeds PFB `sync_in`.
- drop_flag  out  1  sticky; set when a partial word is discarded.

## Operation
- Beat counter `bcnt` (0..R-1) selects the slot; beat b occupies lanes b*IN_LANES .. b*IN_LANES+IN_LANES-1.
- Each valid beat writes its slot of a holding register, then increments `bcnt`.
- When bcnt=R-1 on a valid beat, the completed word (including the current beat) is registered to dout and dout_valid pulses. bcnt wraps to 0.
- Gaps (din_valid=0) hold all state; there is no timeout.
- Word counter `wcnt` (0..PFB_SIZE/LANES-1) increments on each emitted word and wraps.
- sync_in with din_valid:
  - That beat goes to slot 0; bcnt restarts.
  - Any partially filled word (bcnt≠0) is discarded and drop_flag is set.
  - wcnt is forced so the word started by this beat is word 0. The block becomes armed.
- sync_out pulses with dout_valid of the first word completed after each accepted sync_in.
- Back-to-back sync_in before the word completes: the latest one wins, and the earlier partial word counts as a drop.
- Unarmed after reset: packing runs from the first valid beat at slot 0, but sync_out stays 0 until the first sync_in.
- OFFSET_BINARY=1: each sample MSB is inverted on entry. No other arithmetic; widths are preserved.
- drop_flag clears only on reset.

## Timing
- Latency: dout_valid is high the cycle after the clock edge that samples the R-th beat. R=1 gives a plain one-register stage.
- Throughput: one word per R valid beats; at most one dout_valid every R cycles.
- dout holds its last value between strobes.
- Reset (rst_n=0 at an edge):
  - dout=0, dout_valid=0, sync_out=0, drop_flag=0.
  - bcnt=0, wcnt=0, unarmed.
  - A partial word in progress is discarded silently (no drop_flag).
- rst_n=0 has priority over din_valid and sync_in in the same cycle.

## Configuration
- `ADC_PACKER_PERIODIC_SYNC_EN` defined: once armed, sync_out also pulses on every word with wcnt=0, i.e. every PFB_SIZE/LANES words. A new sync_in re-phases the period.
- Not defined: sync_out pulses only once per accepted sync_in, and wcnt is unused for output.

## Structure
- Shared package holds:
  - the `clog2` function;
  - the localparams R = LANES/IN_LANES and FRAME_WORDS = PFB_SIZE/LANES;
  - elaboration checks (LANES%IN_LANES==0, PFB_SIZE%LANES==0), which raise an error on failure.
- One sub-module, `packer_frame_counter`, holds wcnt, the armed bit and sync_out generation, including the macro-dependent logic. The datapath stays in the top module.

## Test plan
- Reset, then 8 valid beats with IN_LANES=2, LANES=4, samples 0..15:
  - dout words {3,2,1,0}, {7,6,5,4}, {11,10,9,8}, {15,14,13,12}, lane 0 in the low bits;
  - each dout_valid occurs one cycle after the completing beat;
  - sync_out stays 0.
- Valid pattern 1,0,0,1,0,1,1 with samples 0..7: two words emitted, identical to the gap-free case; nothing happens on idle cycles.
- One beat, then sync_in on the second beat (samples 4,5), then one more beat (6,7):
  - drop_flag goes to 1;
  - the next word is {7,6,5,4} with sync_out=1 on the same cycle.
- OFFSET_BINARY=1, input 8'h80 and 8'h00 → output lanes 8'h00 and 8'h80.
- With the macro defined and PFB_SIZE=16:
  - sync_in, then 20 continuous words;
  - sync_out is high on words 0, 4, 8, 12 and 16;
  - without the macro, it is high on word 0 only.
- rst_n low for one cycle mid-word, asserted together with din_valid and sync_in:
  - all outputs 0 next cycle;
  - the block is unarmed;
  - the next word starts at slot 0;
  - drop_flag stays 0.

Source files
------------

// File: rtl/adc_lane_packer_pkg.sv
// adc_lane_packer_pkg: shared configuration defaults, derived word/frame
// sizes and constant helper functions for the ADC lane packer.
package adc_lane_packer_pkg;

  localparam int DIN_WIDTH_DEF = 8;
  localparam int IN_LANES_DEF  = 2;
  localparam int LANES_DEF     = 4;
  localparam int PFB_SIZE_DEF  = 64;

  // Beats per packed word and words per PFB frame for the default build.
  localparam int R           = LANES_DEF / IN_LANES_DEF;
  localparam int FRAME_WORDS = PFB_SIZE_DEF / LANES_DEF;

  // Bits needed to hold 0..value-1; never less than one so counters stay legal.
  function automatic int clog2(input int value);
    int width;
    width = 32'sd1;
    while ((32'sd1 << width) < value) begin
      width = width + 32'sd1;
    end
    return width;
  endfunction

  // Input beats that make one packed word.
  function automatic int calc_r(input int lanes, input int in_lanes);
    return (in_lanes > 32'sd0) ? (lanes / in_lanes) : 32'sd1;
  endfunction

  // Packed words that make one PFB frame.
  function automatic int calc_frame_words(input int pfb_size, input int lanes);
    return (lanes > 32'sd0) ? (pfb_size / lanes) : 32'sd1;
  endfunction

  // Legal geometry: whole beats per word and whole words per frame.
  function automatic bit cfg_ok(input int lanes, input int in_lanes, input int pfb_size);
    return (in_lanes > 32'sd0) && (lanes >= in_lanes) &&
           ((lanes % in_lanes) == 32'sd0) && (pfb_size >= lanes) &&
           ((pfb_size % lanes) == 32'sd0);
  endfunction

endpackage

// File: rtl/adc_lane_packer_if.sv
// adc_lane_packer_if: ADC-side beat bus and PFB-side word bus of the packer.
// master = capture/consumer side, slave = the packer itself.
interface adc_lane_packer_if
  import adc_lane_packer_pkg::*;
#(
  parameter int DIN_WIDTH = DIN_WIDTH_DEF,
  parameter int IN_LANES  = IN_LANES_DEF,
  parameter int LANES     = LANES_DEF
);

  logic [IN_LANES*DIN_WIDTH-1:0] din;
  logic                          din_valid;
  logic                          sync_in;
  logic [LANES*DIN_WIDTH-1:0]    dout;
  logic                          dout_valid;
  logic                          sync_out;
  logic                          drop_flag;

  modport master (
    output din, din_valid, sync_in,
    input  dout, dout_valid, sync_out, drop_flag
  );

  modport slave (
    input  din, din_valid, sync_in,
    output dout, dout_valid, sync_out, drop_flag
  );

endinterface

// File: rtl/adc_lane_packer_frame_counter.sv
// packer_frame_counter: word-in-frame counter, armed state and sync_out
// generation. With ADC_PACKER_PERIODIC_SYNC_EN defined, sync_out repeats at
// every frame start once armed; otherwise it fires once per accepted sync.
module packer_frame_counter
  import adc_lane_packer_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_WORDS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_beat,
  input  logic word_done,
  output logic sync_out
);

  localparam int WW = clog2(FRAME_LEN);
  localparam logic [WW-1:0] LAST_WORD = WW'(FRAME_LEN - 1);

  logic [WW-1:0] wcnt_r;
  logic [WW-1:0] wcnt_cur_s;
  logic [WW-1:0] wcnt_inc_s;
  logic          armed_r;
  logic          first_r;
  logic          sync_next_s;
  logic          sync_out_r;

  // Index of the word being completed this cycle and its successor.
  always_comb begin
    wcnt_cur_s  = wcnt_r;
    wcnt_inc_s  = {WW{1'b0}};
    sync_next_s = 1'b0;
    if (sync_beat) begin
      wcnt_cur_s = {WW{1'b0}};
    end else begin
      wcnt_cur_s = wcnt_r;
    end
    if (wcnt_cur_s == LAST_WORD) begin
      wcnt_inc_s = {WW{1'b0}};
    end else begin
      wcnt_inc_s = wcnt_cur_s + WW'(1);
    end
`ifdef ADC_PACKER_PERIODIC_SYNC_EN
    sync_next_s = word_done &&
                  (sync_beat || (armed_r && (first_r || (wcnt_cur_s == {WW{1'b0}}))));
`else
    sync_next_s = word_done && (sync_beat || (armed_r && first_r));
`endif
  end

  // Frame position, arming and the registered frame-start strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_r     <= {WW{1'b0}};
      armed_r    <= 1'b0;
      first_r    <= 1'b0;
      sync_out_r <= 1'b0;
    end else begin
      sync_out_r <= sync_next_s;
      if (sync_beat) begin
        armed_r <= 1'b1;
      end
      if (word_done) begin
        wcnt_r  <= wcnt_inc_s;
        first_r <= 1'b0;
      end else if (sync_beat) begin
        wcnt_r  <= {WW{1'b0}};
        first_r <= 1'b1;
      end
    end
  end

  assign sync_out = sync_out_r;

endmodule

// File: rtl/adc_lane_packer.sv
// adc_lane_packer: gearbox packing IN_LANES-sample beats into LANES-sample
// words (earliest sample in lane 0), optional offset-binary to two's
// complement conversion and PFB frame sync generation. Periodic frame sync
// is enabled by defining ADC_PACKER_PERIODIC_SYNC_EN.
module adc_lane_packer
  import adc_lane_packer_pkg::*;
#(
  parameter int DIN_WIDTH     = DIN_WIDTH_DEF,
  parameter int IN_LANES      = IN_LANES_DEF,
  parameter int LANES         = LANES_DEF,
  parameter int PFB_SIZE      = PFB_SIZE_DEF,
  parameter int OFFSET_BINARY = 0
) (
  input logic               clk,
  input logic               rst_n,
  adc_lane_packer_if.slave  bus
);

  localparam int BEATS     = calc_r(LANES, IN_LANES);
  localparam int FWORDS    = calc_frame_words(PFB_SIZE, LANES);
  localparam int BW        = clog2(BEATS);
  localparam int BEAT_BITS = IN_LANES * DIN_WIDTH;
  localparam int WORD_BITS = LANES * DIN_WIDTH;
  localparam logic [BW-1:0] LAST_SLOT = BW'(BEATS - 1);

  if (!cfg_ok(LANES, IN_LANES, PFB_SIZE)) begin : g_bad_cfg
    $error("adc_lane_packer: LANES must be a multiple of IN_LANES and PFB_SIZE a multiple of LANES");
  end

  if ((LANES == LANES_DEF) && (IN_LANES == IN_LANES_DEF) && (BEATS != R)) begin : g_bad_ratio
    $error("adc_lane_packer: beat ratio disagrees with package default");
  end

  logic [BEAT_BITS-1:0] beat_s;
  logic                 sync_beat_s;
  logic [BW-1:0]        slot_s;
  logic                 word_done_s;
  logic [WORD_BITS-1:0] word_s;
  logic [WORD_BITS-1:0] hold_r;
  logic [BW-1:0]        bcnt_r;
  logic [WORD_BITS-1:0] dout_r;
  logic                 dout_valid_r;
  logic                 drop_flag_r;
  logic                 sync_out_s;

  // Incoming samples, with each MSB flipped when the ADC is offset-binary.
  always_comb begin
    beat_s = bus.din;
    if (OFFSET_BINARY != 0) begin
      for (int k = 0; k < IN_LANES; k++) begin
        beat_s[DIN_WIDTH*k + DIN_WIDTH - 1] = ~bus.din[DIN_WIDTH*k + DIN_WIDTH - 1];
      end
    end else begin
      beat_s = bus.din;
    end
  end

  // Slot selection (sync restarts at slot 0) and the word including this beat.
  always_comb begin
    sync_beat_s = bus.din_valid & bus.sync_in;
    slot_s      = bcnt_r;
    if (sync_beat_s) begin
      slot_s = {BW{1'b0}};
    end else begin
      slot_s = bcnt_r;
    end
    word_done_s = bus.din_valid && (slot_s == LAST_SLOT);
    word_s      = hold_r;
    word_s[slot_s*BEAT_BITS +: BEAT_BITS] = beat_s;
  end

  // Holding register and beat counter; gaps freeze everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_r <= {WORD_BITS{1'b0}};
      bcnt_r <= {BW{1'b0}};
    end else if (bus.din_valid) begin
      hold_r <= word_s;
      if (word_done_s) begin
        bcnt_r <= {BW{1'b0}};
      end else begin
        bcnt_r <= slot_s + BW'(1);
      end
    end
  end

  // Output word register, word strobe and sticky drop indicator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_r       <= {WORD_BITS{1'b0}};
      dout_valid_r <= 1'b0;
      drop_flag_r  <= 1'b0;
    end else begin
      dout_valid_r <= word_done_s;
      if (word_done_s) begin
        dout_r <= word_s;
      end
      if (sync_beat_s && (bcnt_r != {BW{1'b0}})) begin
        drop_flag_r <= 1'b1;
      end
    end
  end

  packer_frame_counter #(
    .FRAME_LEN (FWORDS)
  ) u_frame_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync_beat (sync_beat_s),
    .word_done (word_done_s),
    .sync_out  (sync_out_s)
  );

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.drop_flag  = drop_flag_r;
  assign bus.sync_out   = sync_out_s;

endmodule
